// File: rtl/mips_dmem_pkg.sv
// Shared constants for the MIPS data-side memory/IO responder: I/O page tag,
// register offsets, timer control bit positions and timer state encoding.
package mips_dmem_pkg;

  localparam logic [15:0] IO_TAG = 16'hFFFF;

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_CYCLE = 8'h08;
  localparam logic [7:0] OFF_LOAD  = 8'h0C;
  localparam logic [7:0] OFF_CTRL  = 8'h10;
  localparam logic [7:0] OFF_STAT  = 8'h14;
  localparam logic [7:0] OFF_COUNT = 8'h18;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/mips_dmem_io_timer.sv
// Countdown timer for the I/O page: LOAD/CTRL/STAT/COUNT registers, IDLE/RUN
// FSM and registered interrupt. Only instantiated when MIPS_DMEM_TIMER_EN is set.
module dmem_timer
  import mips_dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [7:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [2:0]  ctrl_o,
  output logic        exp_o,
  output logic [31:0] count_o,
  output logic        irq_o
);

  tmr_state_e  state_q;
  logic [31:0] load_q, count_q;
  logic [2:0]  ctrl_q;
  logic        exp_q, irq_q;
  logic        expire, ctrl_we;

  assign expire  = (state_q == TMR_RUN) && (count_q == 32'd0);
  assign ctrl_we = we_i && (off_i == OFF_CTRL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TMR_IDLE;
      load_q  <= '0;
      count_q <= '0;
      ctrl_q  <= '0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= exp_q & ctrl_q[CTRL_IRQEN];
      if (we_i && (off_i == OFF_LOAD)) load_q <= wdata_i;
      // A same-edge expiry outranks the software clear.
      if (expire) exp_q <= 1'b1;
      else if (we_i && (off_i == OFF_STAT) && wdata_i[0]) exp_q <= 1'b0;
      if (ctrl_we) begin
        ctrl_q <= wdata_i[2:0];
        if (wdata_i[CTRL_EN]) begin
          state_q <= TMR_RUN;
          count_q <= load_q;
        end else begin
          state_q <= TMR_IDLE;
        end
      end else if (state_q == TMR_RUN) begin
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else if (ctrl_q[CTRL_AUTO]) begin
          count_q <= load_q;
        end else begin
          ctrl_q[CTRL_EN] <= 1'b0;
          state_q         <= TMR_IDLE;
        end
      end
    end
  end

  assign load_o  = load_q;
  assign ctrl_o  = ctrl_q;
  assign exp_o   = exp_q;
  assign count_o = count_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/mips_dmem_io.sv
// Data memory + I/O page for the single-cycle MIPS core. Combinational reads,
// clocked writes. Timer block present only when MIPS_DMEM_TIMER_EN is defined.
module mips_dmem_io
  import mips_dmem_pkg::*;
#(
  parameter int RAM_AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic        irq
);

  logic              io_sel, io_we, ram_we;
  logic [7:0]        off;
  logic [RAM_AW-1:0] widx;
  logic [31:0]       ram_q [2**RAM_AW];
  logic [7:0]        leds_q, sw_meta_q, sw_sync_q;
  logic [31:0]       cycle_q, cycle_d;
  logic              unused_addr;

  assign io_sel      = (memaddr[31:16] == IO_TAG);
  assign off         = memaddr[7:0];
  assign widx        = memaddr[RAM_AW+1:2];
  assign io_we       = memwrite && io_sel;
  assign ram_we      = memwrite && !io_sel;
  assign unused_addr = ^memaddr;

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[widx] <= memwritedata;
  end

  assign cycle_d = (io_we && (off == OFF_CYCLE)) ? 32'd0 : cycle_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (io_we && (off == OFF_LED)) leds_q <= memwritedata[7:0];
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      cycle_q   <= cycle_d;
    end
  end

  assign leds = leds_q;

`ifdef MIPS_DMEM_TIMER_EN
  logic [31:0] tmr_load, tmr_count;
  logic [2:0]  tmr_ctrl;
  logic        tmr_exp;

  dmem_timer u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (io_we),
    .off_i   (off),
    .wdata_i (memwritedata),
    .load_o  (tmr_load),
    .ctrl_o  (tmr_ctrl),
    .exp_o   (tmr_exp),
    .count_o (tmr_count),
    .irq_o   (irq)
  );
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    memreaddata = 32'd0;
    if (io_sel) begin
      case (off)
        OFF_LED:   memreaddata = {24'd0, leds_q};
        OFF_SW:    memreaddata = {24'd0, sw_sync_q};
        OFF_CYCLE: memreaddata = cycle_q;
`ifdef MIPS_DMEM_TIMER_EN
        OFF_LOAD:  memreaddata = tmr_load;
        OFF_CTRL:  memreaddata = {29'd0, tmr_ctrl};
        OFF_STAT:  memreaddata = {31'd0, tmr_exp};
        OFF_COUNT: memreaddata = tmr_count;
`endif
        default:   memreaddata = 32'd0;
      endcase
    end else begin
      memreaddata = ram_q[memaddr[RAM_AW+1:2]];
    end
  end

endmodule

// File: doc/mips_dmem_io.md
# mips_dmem_io

Data-side memory responder for the single-cycle MIPS core: answers the core's `memwrite`/`memaddr`/`memwritedata`/`memreaddata` port with a word RAM plus a small memory-mapped I/O page. The I/O page holds an LED register, synchronized switch inputs, a free-running cycle counter and an optional countdown timer with interrupt. It sits beside the core in `mipstop`. Reads are combinational so the core completes loads in one cycle; all writes and state updates are clocked.

## Interface
- `RAM_AW`, 6, RAM word-address bits (2^RAM_AW words)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `memwrite`  in  1  store strobe from core, sampled at rising edge
- `memaddr`  in  32  byte address from core; bits [1:0] ignored (word access)
- `memwritedata`  in  32  store data
- `memreaddata`  out  32  read data, combinational from `memaddr`
- `switches`  in  8  asynchronous board switches
- `leds`  out  8  LED register
- `irq`  out  1  registered timer interrupt

## Operation
- Decode: `memaddr[31:16]==16'hFFFF` selects I/O; otherwise RAM at word index `memaddr[RAM_AW+1:2]`, upper bits aliased.
- RAM: write at edge when `memwrite` and RAM selected; not reset.
- I/O offsets (`memaddr[7:0]`):
  - 0x00 LED: RW, bits [7:0]; reads zero-extended.
  - 0x04 SW: RO, `switches` through 2-flop synchronizer.
  - 0x08 CYCLE: 32-bit up-counter, +1 every cycle, wraps 0xFFFFFFFF→0; any write clears to 0 (write beats increment).
  - 0x0C TMR_LOAD: RW 32.
  - 0x10 TMR_CTRL: RW, bit0 EN, bit1 AUTO, bit2 IRQEN.
  - 0x14 TMR_STAT: bit0 EXP; write 1 to clear.
  - 0x18 TMR_COUNT: RO.
  - Unmapped offsets: read 0, writes ignored.
- Timer FSM, states IDLE, RUN:
  - IDLE→RUN: write to CTRL with EN=1; COUNT←LOAD on that edge.
  - RUN, COUNT≠0: COUNT−1 per cycle.
  - RUN, COUNT==0: EXP←1. If AUTO, COUNT←LOAD and stay in RUN. Otherwise EN←0 and go to IDLE.
  - RUN→IDLE: write to CTRL with EN=0; COUNT holds.
  - Write to CTRL with EN=1 while in RUN: restart, COUNT←LOAD.
  - Expiry and W1C in the same cycle: set wins (EXP=1).
- `irq` ← EXP & IRQEN, registered one cycle.

## Timing
- Reset values: `leds`=0, `irq`=0, CYCLE=0, LOAD=0, CTRL=0, EXP=0, COUNT=0, FSM=IDLE, synchronizer=0.
- `memreaddata` has zero-cycle latency. A read in the same cycle as a write returns old data; new data is visible the cycle after the edge.
- SW reflects a `switches` change 2 edges later.
- LOAD=N: EXP rises N+1 edges after the enabling write.
- LOAD=0: EXP rises on the first RUN edge.
- `irq` rises one edge after EXP.
- Reset asserted mid-count returns everything to reset values immediately. No expiry is reported.

## Configuration
- `MIPS_DMEM_TIMER_EN` defined: timer registers, FSM and `irq` are present as described.
- Undefined: offsets 0x0C–0x18 behave as unmapped, `irq` is tied 0, and the timer logic is absent. LED, SW, CYCLE and RAM are unchanged.

## Structure
- Package `mips_dmem_pkg`:
  - I/O page tag 16'hFFFF
  - register offset constants
  - CTRL bit indices (EN, AUTO, IRQEN)
  - timer state encoding (IDLE, RUN)
- Sub-module `dmem_timer` holds the LOAD/CTRL/STAT/COUNT registers, FSM and `irq` flop. It has write-enable/offset/data inputs and readback outputs, and is instantiated only under the macro.
- Top holds decode, RAM, LED, synchronizer, CYCLE and the read mux.

## Test plan
- Write 0xDEADBEEF to 0x00000010, read 0x00000010 and 0x00000013 → 0xDEADBEEF both. Same-cycle read during write → prior value.
- Write 0x1A5 to 0xFFFF0000 → `leds`=0xA5 next cycle, read 0x000000A5. Set `switches`=0x3C → SW reads 0x3C after 2 edges.
- Let CYCLE run 10 cycles after reset → reads 10. Write any value → reads 0 next cycle, then 1.
- LOAD=3, CTRL=0x5 → EXP at edge 4, `irq` at edge 5, FSM IDLE, CTRL EN=0. Write 1 to STAT → EXP=0 and `irq`=0 a cycle later.
- LOAD=2, CTRL=0x7 → EXP every 3 cycles, COUNT sequence 2,1,0,2,1,0. W1C on the expiry cycle → EXP stays 1.
- Drop `reset` with COUNT=5 → all outputs 0 immediately. Without `MIPS_DMEM_TIMER_EN`, read 0xFFFF0018 → 0 and `irq`=0.
